// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 434;
    localparam int unsigned UART_DATA_W       = 8;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO: synchronous push/pop, head shown combinationally.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       head_c,
    output logic [$clog2(DEPTH):0] count_c,
    output logic                   full_c,
    output logic                   empty_c
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (wptr_q == rptr_q);
    assign full_c  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_c = wptr_q - rptr_q;
    assign head_c  = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign do_pop  = pop_i && !empty_c;
    assign do_push = push_i && (!full_c || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata_i;
                wptr_q                <= wptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with valid/ack handshake and sticky frame/overrun flags.
// Define UART_RX_FIFO_EN to buffer bytes in a uart_rx_fifo instead of one holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
`ifdef UART_RX_FIFO_EN
    ,
    parameter int unsigned FIFO_DEPTH   = 4
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   rd,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned      BIT_W     = $clog2(UART_DATA_W);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    logic                   rx_meta_q;
    logic                   rxs_q;
    uart_state_e            state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_W-1:0]       bit_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   stop_ok_c;
    logic                   stop_bad_c;
    logic                   drop_c;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            unique case (state_q)
                UART_IDLE: begin
                    if (!rxs_q) begin
                        cnt_q   <= '0;
                        state_q <= UART_START;
                    end
                end
                UART_START: begin
                    if (cnt_q == HALF_LAST) begin
                        if (rxs_q) begin
                            state_q <= UART_IDLE;
                        end else begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= UART_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                UART_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs_q, shift_q[UART_DATA_W-1:1]};
                        if (bit_q == DATA_LAST) begin
                            state_q <= UART_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                UART_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= UART_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= UART_IDLE;
            endcase
        end
    end

    assign stop_ok_c  = (state_q == UART_STOP) && (cnt_q == BIT_LAST) && rxs_q;
    assign stop_bad_c = (state_q == UART_STOP) && (cnt_q == BIT_LAST) && !rxs_q;

`ifdef UART_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (stop_ok_c),
        .pop_i   (rd),
        .wdata_i (shift_q),
        .head_c  (rx_data),
        .count_c (),
        .full_c  (fifo_full),
        .empty_c (fifo_empty)
    );

    assign rx_valid = !fifo_empty;
    assign drop_c   = stop_ok_c && fifo_full && !rd;
`else
    logic [UART_DATA_W-1:0] data_q;
    logic                   valid_q;

    // A new byte replaces the held one only if it is free or being acknowledged now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (stop_ok_c && (!valid_q || rd)) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
        end else if (rd) begin
            valid_q <= 1'b0;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign drop_c   = stop_ok_c && valid_q && !rd;
`endif

    // Sticky flags: setting wins over the rd clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (stop_bad_c) begin
                frame_err_q <= 1'b1;
            end else if (rd) begin
                frame_err_q <= 1'b0;
            end
            if (drop_c) begin
                overrun_q <= 1'b1;
            end else if (rd) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit, directed table plus random frames.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned CAP = 4;
`else
    localparam int unsigned CAP = 1;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       rd    = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned last_start = 0;
    int unsigned rise_cyc   = 0;
    logic        prev_valid = 1'b0;

    // Frame-level reference model: queue of pending bytes plus sticky flags.
    logic [7:0] mq[$];
    logic       m_ferr;
    logic       m_ovr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd_after;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd        (rd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        last_start = cyc;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
        rx = stop;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        mq.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop);
        if (!stop) m_ferr = 1'b1;
        else if (mq.size() < CAP) mq.push_back(d);
        else m_ovr = 1'b1;
    endtask

    task automatic model_rd();
        if (mq.size() > 0) void'(mq.pop_front());
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, "_data"}, 32'(rx_data), 32'(mq[0]));
        check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    initial begin
        int unsigned lat;
        logic [7:0]  rd8;
        logic        rstop;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};
        vecs[6] = '{8'h7E, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};

        // Reset values, checked while reset is still asserted.
        tick(2);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        do_reset();

        // First-frame latency from start edge to rx_valid.
        send_frame(8'hA5, 1'b1);
        tick(2);
        lat = rise_cyc - last_start;
        total++;
        if (lat < 154 || lat > 156) begin
            bad++;
            $display("FAIL latency: got %0d want 155 (+-1)", lat);
        end
        check("lat_data", 32'(rx_data), 32'hA5);
        check("lat_ferr", 32'(frame_err), 32'd0);
        pulse_rd();
        tick(16);

        // 4-cycle glitch is rejected as a false start.
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(20);
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_state", 32'(dut.state_q), 32'(UART_IDLE));
        send_frame(8'h3C, 1'b1);
        tick(2);
        check("post_glitch_valid", 32'(rx_valid), 32'd1);
        check("post_glitch_data", 32'(rx_data), 32'h3C);
        pulse_rd();
        tick(16);

        // Directed table.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            tick(1);
            check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
            if (vecs[i].rd_after) begin
                pulse_rd();
                check($sformatf("vec%0d_rd_valid", i), 32'(rx_valid), 32'd0);
                check($sformatf("vec%0d_rd_ferr", i), 32'(frame_err), 32'd0);
            end
            tick(16);
        end

`ifdef UART_RX_FIFO_EN
        // Five back-to-back frames into a depth-4 FIFO.
        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        tick(2);
        check("fifo_ovr", 32'(overrun), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("fifo_pop%0d_valid", i), 32'(rx_valid), 32'd1);
            check($sformatf("fifo_pop%0d_data", i), 32'(rx_data), 32'(i));
            pulse_rd();
        end
        check("fifo_empty_valid", 32'(rx_valid), 32'd0);
        check("fifo_ovr_cleared", 32'(overrun), 32'd0);
`else
        // Second byte with no acknowledge is dropped.
        do_reset();
        send_frame(8'h11, 1'b1);
        tick(16);
        send_frame(8'h22, 1'b1);
        tick(1);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);

        // rd in the exact completion cycle lets the new byte in.
        do_reset();
        send_frame(8'h11, 1'b1);
        tick(16);
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(154);
                rd = 1'b1;
                tick(1);
                rd = 1'b0;
            end
        join
        tick(1);
        check("rdhit_data", 32'(rx_data), 32'h22);
        check("rdhit_valid", 32'(rx_valid), 32'd1);
        check("rdhit_ovr", 32'(overrun), 32'd0);
`endif

        // Reset in the middle of data bits aborts the frame cleanly.
        do_reset();
        send_frame(8'h5A, 1'b1);
        tick(16);
        send_frame(8'h33, 1'b0);
        tick(16);
        check("pre_rst_ferr", 32'(frame_err), 32'd1);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        rx = 1'b0;
        tick(CPB / 2);
        reset = 1'b0;
        tick(1);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_data", 32'(rx_data), 32'h00);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        check("midrst_ovr", 32'(overrun), 32'd0);
        rx = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(40);
        check("after_rst_valid", 32'(rx_valid), 32'd0);
        check("after_rst_state", 32'(dut.state_q), 32'(UART_IDLE));
        send_frame(8'hF0, 1'b1);
        tick(1);
        check("after_rst_rx_valid", 32'(rx_valid), 32'd1);
        check("after_rst_rx_data", 32'(rx_data), 32'hF0);
        check("after_rst_rx_ferr", 32'(frame_err), 32'd0);
        tick(16);

        // Random frames against the frame-level model.
        do_reset();
        for (int n = 0; n < 24; n++) begin
            rd8   = 8'($urandom);
            rstop = ($urandom_range(0, 7) != 0);
            send_frame(rd8, rstop);
            tick(1);
            model_frame(rd8, rstop);
            check_model($sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                pulse_rd();
                model_rd();
                check_model($sformatf("rnd%0d_rd", n));
            end
            tick(16 + int'($urandom_range(0, 8)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end feeding the CPU-visible serial device. Recovers 8N1 frames from the `rx` pin, checks framing and presents each received byte with a valid/acknowledge handshake. Its `rx_data` and status outputs are the byte and status fields packed into the device's readable status word. An optional receive FIFO absorbs bursts while the single-cycle core is busy.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200 baud). Must be at least 4.
- `FIFO_DEPTH`, default 4: entries in the receive FIFO. Must be a power of two. Used only with `UART_RX_FIFO_EN`.

Ports:
- `clk`  in  1: the single system clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `rx`  in  1: serial input pin, asynchronous to `clk`. Idle level is 1.
- `rd`  in  1: one-cycle acknowledge/pop pulse from the CPU read path.
- `rx_data`  out  8: oldest unacknowledged byte.
- `rx_valid`  out  1: `rx_data` holds an unread byte.
- `frame_err`  out  1: sticky flag. A frame was discarded because its stop bit sampled 0.
- `overrun`  out  1: sticky flag. A completed byte was dropped because there was no room for it.

## Operation
- `rx` passes through a two-flop synchronizer. All logic uses the synchronized value `rxs`.
- Bit timer: counter `cnt` counts 0 to `CLKS_PER_BIT-1`. Bit counter: 0 to 7.
- State machine states are IDLE, START, DATA and STOP.
  - IDLE: when `rxs`=0, clear `cnt` and go to START.
  - START: when `cnt` = `CLKS_PER_BIT/2 - 1`, sample `rxs`.
    - If the sample is 1, the low pulse was a false start; return to IDLE.
    - If the sample is 0, clear `cnt`, clear the bit counter and go to DATA.
  - DATA: each time `cnt` = `CLKS_PER_BIT-1`, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: when `cnt` = `CLKS_PER_BIT-1`, sample `rxs`, then return to IDLE.
    - If the sample is 1, the frame completes (a write event).
    - If the sample is 0, the byte is discarded and `frame_err` is set.
- Because STOP returns to IDLE at mid-stop-bit, back-to-back frames with no idle gap are received.
- Holding register (no FIFO):
  - A write event while `rx_valid`=0 loads `rx_data` and sets `rx_valid`.
  - A write event while `rx_valid`=1 and `rd`=0 drops the new byte and sets `overrun`. `rx_data` keeps the old byte.
  - A write event with `rd`=1 in the same cycle loads the new byte. `rx_valid` stays 1 and `overrun` is not set.
  - `rd` with `rx_valid`=1 clears `rx_valid` on the next edge.
  - `rd` with `rx_valid`=0 is ignored.
- Sticky flags: `rd` clears both `frame_err` and `overrun`. Clearing by `rd` has lower priority than setting the flag in the same cycle.

## Timing
- Reset values: `rx_valid`=0, `frame_err`=0, `overrun`=0, `rx_data`=8'h00, state IDLE, counters 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame with no flag. After release, the receiver waits for the next falling edge on `rxs`.
- Latency: `rx_valid` rises 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles (±1) after the falling start edge on `rx`.
- `rx_data` is stable for as long as `rx_valid`=1 and no `rd` arrives.
- `rd` is sampled only on the clock edge. Holding `rd` high for N cycles pops up to N entries.

## Configuration
`UART_RX_FIFO_EN`
- Defined: the holding register is replaced by a `FIFO_DEPTH` FIFO.
  - `rx_valid` means the FIFO is not empty. `rx_data` is the head entry, shown combinationally from the FIFO memory.
  - A write while the FIFO is full sets `overrun` and drops the byte, unless `rd` is asserted in the same cycle. In that case the pop and the push both occur and the count is unchanged.
  - Pointers are `log2(FIFO_DEPTH)+1` bits wide and wrap naturally. The MSB distinguishes full from empty.
- Undefined: single holding register as described under Operation.

## Structure
- Package `uart_pkg` holds:
  - the state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`);
  - the default `CLKS_PER_BIT` constant;
  - the data-width constant, 8.
- Sub-module `uart_rx_fifo` has synchronous push/pop, count, full and empty. It is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Send 8'hA5 as an 8N1 frame: `rx_valid`=1 with `rx_data`=8'hA5 within 2+8+144+1 cycles of the start edge (±1). `frame_err`=0.
- A 4-cycle low glitch on `rx`: no `rx_valid`, state back in IDLE, and the next 8'h3C frame is received correctly.
- Frame 8'h55 with a 0 stop bit: `rx_valid` stays 0 and `frame_err`=1. A `rd` pulse clears it.
- Without FIFO, send 8'h11 then 8'h22 with no `rd`: `rx_data`=8'h11 and `overrun`=1. Repeat with `rd` pulsed in the exact cycle the second byte completes: `rx_data`=8'h22, `overrun`=0.
- With `UART_RX_FIFO_EN` and depth 4, send 8'h01 to 8'h05 back-to-back with no gap: `overrun`=1, and the pops return 01, 02, 03, 04, then `rx_valid`=0.
- Assert `reset` (0) midway through a frame's data bits: all outputs return to reset values, and a subsequent 8'hF0 frame is received correctly.
